// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the hazard scoreboard. Pure declarations.
// No latency, no flow control.
package hazard_pkg;

    localparam int AW_DEF   = 5;
    localparam int TW_DEF   = 2;
    localparam int REG_ZERO = 0;
    // Widest Tnew/Tuse the decrement helper supports; narrower fields zero-extend.
    localparam int TW_MAX   = 8;

    // Saturating decrement: zero stays zero. Callers cast to and from TW bits,
    // which is exact because the result never exceeds the input.
    function automatic logic [TW_MAX-1:0] sat_dec(input logic [TW_MAX-1:0] x);
        return (x == '0) ? '0 : x - TW_MAX'(1);
    endfunction

endpackage

// File: rtl/hazard_stage.sv
// One tracked pipeline slot {dst, tnew}; captures its input every edge with tnew decremented.
// Latency one edge; flush or bubble loads the empty entry, never stalls itself.
module hazard_stage
    import hazard_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int TW = TW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          bubble,
    input  logic [AW-1:0] in_dst,
    input  logic [TW-1:0] in_tnew,
    output logic [AW-1:0] dst,
    output logic [TW-1:0] tnew
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dst  <= '0;
            tnew <= '0;
        end else if (flush || bubble) begin
            dst  <= AW'(REG_ZERO);
            tnew <= '0;
        end else begin
            dst  <= in_dst;
            tnew <= TW'(sat_dec(TW_MAX'(in_tnew)));
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks {dst, tnew} behind decode, raises stall and picks forwarding stage.
// stall/fwd_sel are combinational (zero latency); stall bubbles stage 0 only, downstream keeps draining.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int AW     = AW_DEF,
    parameter int TW     = TW_DEF,
    parameter int NSRC   = 2,
    parameter int CNTW   = 16,
    localparam int SW    = $clog2(STAGES + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [NSRC*AW-1:0]   id_src,
    input  logic [NSRC*TW-1:0]   id_tuse,
    input  logic [AW-1:0]        id_dst,
    input  logic [TW-1:0]        id_tnew,
    input  logic                 hold,
    input  logic                 flush,
    output logic                 stall,
    output logic [NSRC*SW-1:0]   fwd_sel,
    output logic [STAGES*AW-1:0] stage_dst,
    output logic [STAGES*TW-1:0] stage_tnew,
    output logic [CNTW-1:0]      stall_count
);

    logic [AW-1:0] dst_q  [STAGES];
    logic [TW-1:0] tnew_q [STAGES];
    logic          bubble0;
    logic [CNTW-1:0] cnt_q;

    assign bubble0 = stall | hold | ~id_valid;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        if (g == 0) begin : g_head
            hazard_stage #(.AW(AW), .TW(TW)) u_stage (
                .clk     (clk),
                .reset   (reset),
                .flush   (flush),
                .bubble  (bubble0),
                .in_dst  (id_dst),
                .in_tnew (id_tnew),
                .dst     (dst_q[g]),
                .tnew    (tnew_q[g])
            );
        end else begin : g_tail
            hazard_stage #(.AW(AW), .TW(TW)) u_stage (
                .clk     (clk),
                .reset   (reset),
                .flush   (flush),
                .bubble  (1'b0),
                .in_dst  (dst_q[g-1]),
                .in_tnew (tnew_q[g-1]),
                .dst     (dst_q[g]),
                .tnew    (tnew_q[g])
            );
        end
        assign stage_dst[g*AW +: AW]  = dst_q[g];
        assign stage_tnew[g*TW +: TW] = tnew_q[g];
    end

    logic [AW-1:0] src;
    logic [TW-1:0] tuse;
    logic          hit;
    logic [TW-1:0] hit_tnew;
    logic [SW-1:0] hit_sel;

    always_comb begin
        stall    = 1'b0;
        fwd_sel  = '0;
        src      = '0;
        tuse     = '0;
        hit      = 1'b0;
        hit_tnew = '0;
        hit_sel  = '0;
        for (int i = 0; i < NSRC; i++) begin
            src      = id_src[i*AW +: AW];
            tuse     = id_tuse[i*TW +: TW];
            hit      = 1'b0;
            hit_tnew = '0;
            hit_sel  = '0;
            // Walk oldest to youngest so the youngest match overwrites and shadows older ones.
            for (int k = STAGES - 1; k >= 0; k--) begin
                if (src != AW'(REG_ZERO) && src == dst_q[k]) begin
                    hit      = 1'b1;
                    hit_tnew = tnew_q[k];
                    hit_sel  = SW'(k + 1);
                end
            end
            if (id_valid && hit && (hit_tnew > tuse)) begin
                stall = 1'b1;
            end
            if (hit && hit_tnew == '0) begin
                fwd_sel[i*SW +: SW] = hit_sel;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (stall && !flush && cnt_q != '1) begin
            cnt_q <= cnt_q + CNTW'(1);
        end
    end

    assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    localparam int S    = 3;
    localparam int AW   = 5;
    localparam int TW   = 2;
    localparam int NSRC = 2;
    localparam int CNTW = 4;
    localparam int SW   = 2;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 id_valid = 1'b0;
    logic [NSRC*AW-1:0]   id_src = '0;
    logic [NSRC*TW-1:0]   id_tuse = '0;
    logic [AW-1:0]        id_dst = '0;
    logic [TW-1:0]        id_tnew = '0;
    logic                 hold = 1'b0;
    logic                 flush = 1'b0;
    logic                 stall;
    logic [NSRC*SW-1:0]   fwd_sel;
    logic [S*AW-1:0]      stage_dst;
    logic [S*TW-1:0]      stage_tnew;
    logic [CNTW-1:0]      stall_count;

    hazard_scoreboard #(.STAGES(S), .AW(AW), .TW(TW), .NSRC(NSRC), .CNTW(CNTW)) dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_src      (id_src),
        .id_tuse     (id_tuse),
        .id_dst      (id_dst),
        .id_tnew     (id_tnew),
        .hold        (hold),
        .flush       (flush),
        .stall       (stall),
        .fwd_sel     (fwd_sel),
        .stage_dst   (stage_dst),
        .stage_tnew  (stage_tnew),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model of the tracked stages and the counter.
    logic [AW-1:0] md [S];
    logic [TW-1:0] mt [S];
    logic [CNTW-1:0] mc;
    logic m_stall;

    typedef struct packed {
        logic            stall;
        logic [3:0]      fwd;
        logic [14:0]     sdst;
        logic [5:0]      stnew;
        logic [CNTW-1:0] cnt;
    } exp_t;

    exp_t q[$];

    function automatic logic [TW-1:0] mdec(input logic [TW-1:0] x);
        return (x == 2'd0) ? 2'd0 : x - 2'd1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < S; k++) begin
            md[k] = '0;
            mt[k] = '0;
        end
        mc = '0;
        m_stall = 1'b0;
    endtask

    task automatic predict();
        exp_t e;
        logic [AW-1:0] s;
        logic [TW-1:0] u;
        logic found;
        e = '0;
        for (int i = 0; i < NSRC; i++) begin
            s = id_src[i*AW +: AW];
            u = id_tuse[i*TW +: TW];
            found = 1'b0;
            for (int k = 0; k < S; k++) begin
                if (!found && s != 5'd0 && s == md[k]) begin
                    found = 1'b1;
                    if (id_valid && mt[k] > u) e.stall = 1'b1;
                    if (mt[k] == 2'd0) e.fwd[i*SW +: SW] = 2'(k + 1);
                end
            end
        end
        e.sdst  = {md[2], md[1], md[0]};
        e.stnew = {mt[2], mt[1], mt[0]};
        e.cnt   = mc;
        m_stall = e.stall;
        q.push_back(e);
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            chk({tag, ".queue_empty"}, 32'd1, 32'd0);
            return;
        end
        e = q.pop_front();
        chk({tag, ".stall"}, 32'(stall), 32'(e.stall));
        chk({tag, ".fwd"}, 32'(fwd_sel), 32'(e.fwd));
        chk({tag, ".sdst"}, 32'(stage_dst), 32'(e.sdst));
        chk({tag, ".stnew"}, 32'(stage_tnew), 32'(e.stnew));
        chk({tag, ".cnt"}, 32'(stall_count), 32'(e.cnt));
    endtask

    task automatic apply(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                         input logic [1:0] u0, input logic [1:0] u1,
                         input logic [4:0] d, input logic [1:0] t,
                         input logic h, input logic f, input string tag);
        id_valid = v;
        id_src   = {s1, s0};
        id_tuse  = {u1, u0};
        id_dst   = d;
        id_tnew  = t;
        hold     = h;
        flush    = f;
        #1;
        predict();
        compare(tag);
    endtask

    task automatic tick();
        @(posedge clk);
        if (flush) begin
            for (int k = 0; k < S; k++) begin
                md[k] = '0;
                mt[k] = '0;
            end
        end else begin
            for (int k = S - 1; k > 0; k--) begin
                md[k] = md[k-1];
                mt[k] = mdec(mt[k-1]);
            end
            if (m_stall || hold || !id_valid) begin
                md[0] = '0;
                mt[0] = '0;
            end else begin
                md[0] = id_dst;
                mt[0] = mdec(id_tnew);
            end
        end
        if (m_stall && !flush && mc != 4'hF) mc = mc + 4'd1;
        @(negedge clk);
    endtask

    task automatic idle(input string tag);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        #2;
        chk("rst0_stall", 32'(stall), 32'd0);
        chk("rst0_cnt", 32'(stall_count), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        idle("rst_idle");

        // Load-use against default producer.
        apply(1, 0, 0, 0, 0, 8, 2, 0, 0, "lu0"); tick();
        apply(1, 8, 0, 0, 0, 0, 0, 0, 0, "lu1");
        chk("lu1_stall_const", 32'(stall), 32'd1);
        chk("lu1_s0tnew_const", 32'(stage_tnew[1:0]), 32'd1);
        tick();
        apply(1, 8, 0, 0, 0, 0, 0, 0, 0, "lu2");
        chk("lu2_stall_const", 32'(stall), 32'd0);
        chk("lu2_fwd0_const", 32'(fwd_sel[1:0]), 32'd2);
        chk("lu2_cnt_const", 32'(stall_count), 32'd1);
        tick();

        // id_valid low suppresses stall.
        apply(1, 0, 0, 0, 0, 8, 3, 0, 0, "iv_load"); tick();
        apply(0, 8, 8, 0, 0, 0, 0, 0, 0, "iv_chk");
        chk("iv_stall_const", 32'(stall), 32'd0);
        tick();

        // $0 never matches.
        apply(1, 0, 0, 0, 0, 0, 3, 0, 0, "z_load"); tick();
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0, "z_chk");
        chk("z_stall_const", 32'(stall), 32'd0);
        chk("z_fwd_const", 32'(fwd_sel), 32'd0);
        tick();

        // Shadowing: youngest match wins.
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1, "sh_flush"); tick();
        apply(1, 0, 0, 0, 0, 5, 0, 0, 0, "sh_a0"); tick();
        idle("sh_a1"); tick();
        apply(1, 0, 0, 0, 0, 5, 0, 0, 0, "sh_a2"); tick();
        apply(1, 0, 5, 0, 0, 0, 0, 0, 0, "sh_a3");
        chk("sh_fwd1_const", 32'(fwd_sel[3:2]), 32'd1);
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1, "sh_flush2"); tick();
        apply(1, 0, 0, 0, 0, 5, 0, 0, 0, "sh_b0"); tick();
        idle("sh_b1"); tick();
        apply(1, 0, 0, 0, 0, 5, 3, 0, 0, "sh_b2"); tick();
        apply(1, 0, 5, 0, 1, 0, 0, 0, 0, "sh_b3");
        chk("sh_stall_const", 32'(stall), 32'd1);
        tick();

        // Hold without hazard bubbles stage 0 but does not stall.
        apply(1, 0, 0, 0, 0, 6, 2, 1, 0, "hold0");
        chk("hold_stall_const", 32'(stall), 32'd0);
        tick();
        idle("hold1");
        chk("hold_s0dst_const", 32'(stage_dst[4:0]), 32'd0);

        // Flush beats stall and hold; counter untouched.
        apply(1, 0, 0, 0, 0, 8, 3, 0, 0, "fl_load"); tick();
        apply(1, 8, 0, 0, 0, 0, 0, 1, 1, "fl_edge");
        chk("fl_stall_const", 32'(stall), 32'd1);
        tick();
        idle("fl_after");
        chk("fl_sdst_const", 32'(stage_dst), 32'd0);
        chk("fl_stnew_const", 32'(stage_tnew), 32'd0);

        // Twenty stall cycles saturate the 4-bit counter.
        for (int b = 0; b < 10; b++) begin
            apply(1, 0, 0, 0, 0, 9, 3, 0, 0, "sat_load"); tick();
            apply(1, 9, 0, 0, 0, 0, 0, 0, 0, "sat_s1"); tick();
            apply(1, 9, 0, 0, 0, 0, 0, 0, 0, "sat_s2"); tick();
        end
        idle("sat_end");
        chk("sat_cnt_const", 32'(stall_count), 32'd15);

        // Tnew of 0 stays at the floor through every stage.
        apply(1, 0, 0, 0, 0, 7, 0, 0, 0, "t0_load"); tick();
        for (int k = 0; k < S; k++) begin
            idle("t0_walk");
            chk("t0_stnew_const", 32'(stage_tnew), 32'd0);
            tick();
        end

        // Asynchronous reset mid-stall, no clock edge needed.
        apply(1, 0, 0, 0, 0, 8, 3, 0, 0, "ar_load"); tick();
        apply(1, 8, 0, 0, 0, 0, 0, 0, 0, "ar_stall");
        #2;
        reset = 1'b0;
        #1;
        chk("ar_stall", 32'(stall), 32'd0);
        chk("ar_fwd", 32'(fwd_sel), 32'd0);
        chk("ar_sdst", 32'(stage_dst), 32'd0);
        chk("ar_stnew", 32'(stage_tnew), 32'd0);
        chk("ar_cnt", 32'(stall_count), 32'd0);
        model_reset();
        q.delete();
        @(negedge clk);
        reset = 1'b1;
        apply(1, 8, 0, 0, 0, 0, 0, 0, 0, "ar_after"); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard scoreboard for the pipelined MIPS core. It tracks destination register and Tnew for every in-flight instruction across STAGES pipeline stages behind decode. It inserts bubbles on stall, hold or flush. Combinationally it raises the decode-stage stall and selects, per source operand, the forwarding stage. A saturating stall-cycle counter supports performance analysis.

## Interface
Parameters:
- STAGES, 3, number of tracked stages after decode (stage 0 = E, 1 = M, 2 = W at default)
- AW, 5, register address width
- TW, 2, Tnew/Tuse width
- NSRC, 2, source operands checked per decode instruction
- CNTW, 16, stall counter width
- SW (derived, not overridable), $clog2(STAGES+1), forward-select width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; while low, all state is cleared
- id_valid  in  1  decode holds a real instruction
- id_src  in  NSRC*AW  source register numbers; operand i is at bits [i*AW +: AW]
- id_tuse  in  NSRC*TW  cycles until each source is consumed, same packing
- id_dst  in  AW  destination register; 0 means no write
- id_tnew  in  TW  cycles until the result exists, counted from decode
- hold  in  1  external freeze (e.g. mult/div busy); forces a bubble into stage 0
- flush  in  1  clears every stage
- stall  out  1  decode must not advance (combinational)
- fwd_sel  out  NSRC*SW  per operand: 0 = register file, k = stage k-1
- stage_dst  out  STAGES*AW  dst per stage, for the datapath
- stage_tnew  out  STAGES*TW  Tnew per stage
- stall_count  out  CNTW  number of cycles in which stall=1

## Operation
- Stage state is {dst, tnew}. dst = 0 denotes a bubble and never matches.
- dec(x) is a saturating decrement: dec(0) = 0, otherwise x-1.
- Per clock edge, in priority order:
  - flush: every stage becomes {0,0}.
  - Otherwise, stage 0 is loaded:
    - with {0,0} if stall | hold | !id_valid;
    - else with {id_dst, dec(id_tnew)}.
  - Stage k>0 always loads {dst(k-1), dec(tnew(k-1))}. Stall and hold do not freeze the downstream stages.
- Match for operand i at stage k: src_i != 0 and src_i == dst(k).
- Stall:
  - stall = OR over operands of (id_valid & youngest matching stage has tnew > tuse_i).
  - Only the youngest match (lowest k) is considered; older stages holding the same register are shadowed.
- Forward select:
  - fwd_sel_i = k+1 if the youngest match at stage k has tnew == 0; else 0.
  - No match also gives 0.
- stall_count increments on each edge where stall=1 and flush=0, and saturates at all-ones.
- All arithmetic is unsigned; comparisons are TW-bit.

## Timing
- Reset:
  - Asserting reset low clears all stages, stall_count and, through them, stall and fwd_sel immediately, without waiting for a clock edge.
  - The first edge after release behaves normally.
  - A reset mid-stall discards all in-flight entries.
- stall and fwd_sel are combinational from id_* and the current stage state, with zero latency.
- An instruction accepted at edge n is visible in stage k after edge n+k. Its Tnew falls by one per stage, with a floor of 0.
- flush and stall in the same cycle: flush wins. stall_count still counts that cycle only if flush=0.
- hold=1 with no hazard: stall stays 0, and a bubble is still inserted.
- id_valid=0 suppresses stall regardless of id_src.

## Structure
- Shared package hazard_pkg holds:
  - REG_ZERO constant;
  - the saturating-decrement function, parametrised on TW;
  - the default AW/TW values.
- Sub-module hazard_stage (one {dst, tnew} register with load, bubble and flush) is instantiated STAGES times in a generate loop.
- Match/priority logic and the counter live in the top.

## Test plan
- Reset: hold reset low mid-traffic → all stage_dst/stage_tnew = 0, stall = 0, fwd_sel = 0, stall_count = 0, with no clock edge required.
- Load-use:
  - Cycle 0: id_dst=8, id_tnew=2 (defaults); stage 0 now holds tnew=1.
  - Next cycle: id_src0=8, tuse0=0 → stall=1, bubble enters stage 0.
  - Following cycle: stage 1 holds tnew=0 → stall=0, fwd_sel0=2, stall_count=1.
- $0: stage 0 = {dst 0, tnew 3}, id_src0=0, tuse0=0 → stall=0, fwd_sel0=0.
- Shadowing: stage 0 = {5, 0}, stage 2 = {5, 0}, id_src1=5 → fwd_sel1=1. With stage 0 = {5, 2} and tuse1=1 instead → stall=1.
- Flush: flush=1 with stall=1 and hold=1 on the same edge → all stages {0,0} after the edge, and stall_count is unchanged.
- Saturation: with CNTW=4, force 20 consecutive stall cycles → stall_count stops at 15. Feed id_tnew=0 through all stages → tnew stays 0.
